lcd_arbiter: RTL and testbench

- Shares one LCD character driver (req/busy/done handshake) among NUM_REQ UI requesters, e.g. the select, encode, decode and setting screens.
- Sits between the UI modules and the LCD driver.
- Uses round-robin grant, latches the requester's row/col/char, and runs one write per grant.
- Returns busy and done to requesters with the same handshake the driver uses.

---
 rtl/lcd_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_lcd_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_arbiter.sv
// Round-robin arbiter that shares one LCD character driver among NUM_REQ requesters.
// Optional watchdog is compiled in when LCD_ARB_TIMEOUT_EN is defined.
module lcd_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int GW             = 3,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_req,
    input  logic [2*NUM_REQ-1:0] req_row,
    input  logic [4*NUM_REQ-1:0] req_col,
    input  logic [8*NUM_REQ-1:0] req_char,
    output logic [NUM_REQ-1:0]   req_busy,
    output logic [NUM_REQ-1:0]   req_done,
    output logic                 drv_req,
    output logic [1:0]           drv_row,
    output logic [3:0]           drv_col,
    output logic [7:0]           drv_char,
    input  logic                 drv_busy,
    input  logic                 drv_done,
    output logic                 grant_valid,
    output logic [GW-1:0]        grant_id,
    output logic                 err_timeout
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RELEASE} state_t;

    state_t             r_state, w_state_next;
    logic [GW-1:0]      r_last_grant, w_last_grant_next;
    logic [GW-1:0]      r_grant_id, w_grant_id_next;
    logic               r_grant_valid, w_grant_valid_next;
    logic               r_drv_req, w_drv_req_next;
    logic [NUM_REQ-1:0] r_req_done, w_req_done_next;
    logic [NUM_REQ-1:0] r_req_busy;
    logic [1:0]         r_drv_row;
    logic [3:0]         r_drv_col;
    logic [7:0]         r_drv_char;

    logic               w_latch, w_finish, w_timeout, w_any, w_grant_req;
    logic [GW-1:0]      w_win;
    logic [NUM_REQ-1:0] w_rot, w_is_grant;
    logic [1:0]         w_sel_row;
    logic [3:0]         w_sel_col;
    logic [7:0]         w_sel_char;

    // Rotate so that bit 0 is the requester just after the last winner.
    assign w_rot = NUM_REQ'({req_req, req_req} >> ({1'b0, r_last_grant} + 1'b1));

    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_any = 1'b1;
                w_win = GW'((int'(r_last_grant) + 1 + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        w_sel_row  = '0;
        w_sel_col  = '0;
        w_sel_char = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == GW'(i)) begin
                w_sel_row  = req_row[2*i +: 2];
                w_sel_col  = req_col[4*i +: 4];
                w_sel_char = req_char[8*i +: 8];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_grant_dec
            assign w_is_grant[gi] = (r_grant_id == GW'(gi));
        end
    endgenerate

    assign w_grant_req = |(req_req & w_is_grant);

    always_comb begin
        w_state_next       = r_state;
        w_last_grant_next  = r_last_grant;
        w_grant_id_next    = r_grant_id;
        w_grant_valid_next = r_grant_valid;
        w_drv_req_next     = r_drv_req;
        w_req_done_next    = '0;
        w_latch            = 1'b0;
        w_finish           = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_next       = ISSUE;
                    w_last_grant_next  = w_win;
                    w_grant_id_next    = w_win;
                    w_grant_valid_next = 1'b1;
                    w_drv_req_next     = 1'b1;
                    w_latch            = 1'b1;
                end
            end
            ISSUE: begin
                if (drv_done || w_timeout) begin
                    w_finish = 1'b1;
                end else if (drv_busy) begin
                    w_state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (drv_done || w_timeout) begin
                    w_finish = 1'b1;
                end
            end
            RELEASE: begin
                // Hold the grant until the winner lets go, so a stale request is not re-granted.
                if (!w_grant_req) begin
                    w_state_next       = IDLE;
                    w_grant_valid_next = 1'b0;
                end
            end
            default: w_state_next = IDLE;
        endcase
        if (w_finish) begin
            w_state_next    = RELEASE;
            w_drv_req_next  = 1'b0;
            w_req_done_next = w_is_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_last_grant  <= GW'(NUM_REQ - 1);
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_drv_req     <= 1'b0;
            r_req_done    <= '0;
            r_req_busy    <= '0;
            r_drv_row     <= '0;
            r_drv_col     <= '0;
            r_drv_char    <= '0;
        end else begin
            r_state       <= w_state_next;
            r_last_grant  <= w_last_grant_next;
            r_grant_id    <= w_grant_id_next;
            r_grant_valid <= w_grant_valid_next;
            r_drv_req     <= w_drv_req_next;
            r_req_done    <= w_req_done_next;
            r_req_busy    <= {NUM_REQ{w_state_next != IDLE}};
            if (w_latch) begin
                r_drv_row  <= w_sel_row;
                r_drv_col  <= w_sel_col;
                r_drv_char <= w_sel_char;
            end
        end
    end

`ifdef LCD_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_wd_cnt;
    logic          r_err_timeout;

    assign w_timeout = ((r_state == ISSUE) || (r_state == WAIT_DONE)) && !drv_done
                       && (r_wd_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wd_cnt      <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            if (w_latch) begin
                r_wd_cnt <= '0;
            end else if ((r_state == ISSUE) || (r_state == WAIT_DONE)) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_err_timeout <= 1'b1;
            end
        end
    end

    assign err_timeout = r_err_timeout;
`else
    assign w_timeout   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    assign req_busy    = r_req_busy;
    assign req_done    = r_req_done;
    assign drv_req     = r_drv_req;
    assign drv_row     = r_drv_row;
    assign drv_col     = r_drv_col;
    assign drv_char    = r_drv_char;
    assign grant_valid = r_grant_valid;
    assign grant_id    = r_grant_id;

endmodule

// File: tb/tb_lcd_arbiter.sv
// Self-checking bench for lcd_arbiter: directed table, corner sequences and randomized traffic
// against a round-robin reference model. The watchdog test runs when LCD_ARB_TIMEOUT_EN is defined.
module tb_lcd_arbiter;
    localparam int N  = 4;
    localparam int GW = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_req;
    logic [2*N-1:0] req_row;
    logic [4*N-1:0] req_col;
    logic [8*N-1:0] req_char;
    logic [N-1:0]   req_busy, req_done;
    logic           drv_req;
    logic [1:0]     drv_row;
    logic [3:0]     drv_col;
    logic [7:0]     drv_char;
    logic           drv_busy, drv_done;
    logic           grant_valid;
    logic [GW-1:0]  grant_id;
    logic           err_timeout;

    always #5 clk = ~clk;

    lcd_arbiter #(.NUM_REQ(N), .GW(GW), .TIMEOUT_CYCLES(20)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_req(req_req), .req_row(req_row), .req_col(req_col), .req_char(req_char),
        .req_busy(req_busy), .req_done(req_done),
        .drv_req(drv_req), .drv_row(drv_row), .drv_col(drv_col), .drv_char(drv_char),
        .drv_busy(drv_busy), .drv_done(drv_done),
        .grant_valid(grant_valid), .grant_id(grant_id), .err_timeout(err_timeout)
    );

    typedef struct {
        logic [N-1:0] raise;
        logic [1:0]   row;
        logic [3:0]   col;
        logic [7:0]   chr;
        int           exp_id;
        logic [1:0]   e_row;
        logic [3:0]   e_col;
        logic [7:0]   e_char;
        int           busy;
        bit           early;
        int           hold;
        bit           reraise;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cd [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance to the sampling edge, then apply pending re-raises.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (cd[i] > 0) begin
                cd[i]--;
                if (cd[i] == 0) req_req[i] = 1'b1;
            end
        end
    endtask

    task automatic set_data(input int i, input logic [1:0] r, input logic [3:0] c, input logic [7:0] ch);
        req_row[2*i +: 2]  = r;
        req_col[4*i +: 4]  = c;
        req_char[8*i +: 8] = ch;
    endtask

    task automatic scribble_data(input logic [N-1:0] m);
        for (int i = 0; i < N; i++) begin
            if (m[i]) set_data(i, 2'($urandom), 4'($urandom), 8'($urandom));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; drv_busy = 1'b0; drv_done = 1'b0; req_req = '0;
        for (int i = 0; i < N; i++) cd[i] = 0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    function automatic int rr_pick(input int last, input logic [N-1:0] pend);
        for (int k = 1; k <= N; k++) begin
            if (pend[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // Full transaction starting from an idle arbiter; the bench plays requester and driver.
    task automatic run_txn(input logic [N-1:0] raise, input int exp_id, input logic [1:0] e_row,
                           input logic [3:0] e_col, input logic [7:0] e_char, input int busy_cyc,
                           input bit early, input int hold, input bit reraise, input bit scribble);
        logic [N-1:0] onehot;
        onehot  = N'(1) << exp_id;
        req_req = req_req | raise;
        step();
        chk("grant drv_req", 32'(drv_req), 32'd1);
        chk("grant_valid", 32'(grant_valid), 32'd1);
        chk("grant_id", 32'(grant_id), 32'(exp_id));
        chk("drv_row", 32'(drv_row), 32'(e_row));
        chk("drv_col", 32'(drv_col), 32'(e_col));
        chk("drv_char", 32'(drv_char), 32'(e_char));
        chk("busy all", 32'(req_busy), 32'(4'b1111));
        drv_busy = (busy_cyc > 0);
        for (int c = 0; c < busy_cyc; c++) begin
            step();
            chk("drv_req held", 32'(drv_req), 32'd1);
            chk("no early done", 32'(req_done), 32'd0);
            if (scribble) scribble_data(~req_req | onehot);
            if (early && c == 0) begin
                req_char[8*exp_id +: 8] = e_char + 8'h01;
                req_req[exp_id] = 1'b0;
            end
        end
        drv_busy = 1'b0;
        drv_done = 1'b1;
        step();
        drv_done = 1'b0;
        chk("done drv_req low", 32'(drv_req), 32'd0);
        chk("done pulse", 32'(req_done), 32'(onehot));
        chk("frozen char", 32'(drv_char), 32'(e_char));
        chk("frozen row/col", 32'({drv_row, drv_col}), 32'({e_row, e_col}));
        for (int h = 0; h < hold; h++) begin
            step();
            chk("release grant held", 32'(grant_valid), 32'd1);
            chk("release single pulse", 32'(req_done), 32'd0);
            chk("release no regrant", 32'(drv_req), 32'd0);
            chk("release busy", 32'(req_busy), 32'(4'b1111));
        end
        req_req[exp_id] = 1'b0;
        if (reraise) cd[exp_id] = 2;
        step();
        chk("idle grant_valid", 32'(grant_valid), 32'd0);
        chk("idle busy", 32'(req_busy), 32'd0);
        chk("idle done", 32'(req_done), 32'd0);
        chk("idle drv_req", 32'(drv_req), 32'd0);
        chk("idle err_timeout", 32'(err_timeout), 32'd0);
        $display("txn grant=%0d char=%02h busy=%0d early=%0d hold=%0d checks=%0d fails=%0d",
                 exp_id, e_char, busy_cyc, early, hold, n_checks, n_fail);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t         tbl [7];
        logic [N-1:0] raise;
        int           m_last, exp, busy, hold;
        bit           early;

        req_row = '0; req_col = '0; req_char = '0;
        rst_n = 1'b0; drv_busy = 1'b0; drv_done = 1'b0; req_req = '0;
        for (int i = 0; i < N; i++) cd[i] = 0;
        repeat (2) step();
        chk("reset drv_req", 32'(drv_req), 32'd0);
        chk("reset grant_valid", 32'(grant_valid), 32'd0);
        chk("reset grant_id", 32'(grant_id), 32'd0);
        chk("reset busy", 32'(req_busy), 32'd0);
        chk("reset done", 32'(req_done), 32'd0);
        chk("reset drv data", 32'({drv_row, drv_col, drv_char}), 32'd0);
        chk("reset err_timeout", 32'(err_timeout), 32'd0);
        rst_n = 1'b1;
        step();
        chk("post-reset idle", 32'(drv_req), 32'd0);

        // Single request from requester 1.
        set_data(1, 2'd1, 4'd5, 8'h41);
        run_txn(4'b0010, 1, 2'd1, 4'd5, 8'h41, 2, 1'b0, 0, 1'b0, 1'b0);

        // Requester 2 in flight: everyone stalled; reset in WAIT_DONE aborts cleanly.
        set_data(2, 2'd3, 4'hC, 8'h7E);
        req_req = 4'b0100;
        step();
        chk("r2 grant_id", 32'(grant_id), 32'd2);
        drv_busy = 1'b1;
        step();
        chk("busy to others", 32'(req_busy), 32'(4'b1111));
        rst_n = 1'b0;
        step();
        chk("midreset drv_req", 32'(drv_req), 32'd0);
        chk("midreset grant_valid", 32'(grant_valid), 32'd0);
        chk("midreset done", 32'(req_done), 32'd0);
        chk("midreset busy", 32'(req_busy), 32'd0);
        rst_n = 1'b1; drv_busy = 1'b0; req_req = '0;
        step();

        // Round-robin over 0,1,3 with re-raise, then early drop / data freeze.
        tbl[0] = '{raise:4'b1011, row:2'd2, col:4'd6, chr:8'h55, exp_id:0, e_row:2'd2, e_col:4'd6, e_char:8'h55, busy:1, early:1'b0, hold:0, reraise:1'b1};
        tbl[1] = '{raise:4'b0000, row:2'd0, col:4'd0, chr:8'h00, exp_id:1, e_row:2'd2, e_col:4'd6, e_char:8'h55, busy:0, early:1'b0, hold:1, reraise:1'b1};
        tbl[2] = '{raise:4'b0000, row:2'd0, col:4'd0, chr:8'h00, exp_id:3, e_row:2'd2, e_col:4'd6, e_char:8'h55, busy:2, early:1'b0, hold:0, reraise:1'b1};
        tbl[3] = '{raise:4'b0000, row:2'd0, col:4'd0, chr:8'h00, exp_id:0, e_row:2'd2, e_col:4'd6, e_char:8'h55, busy:1, early:1'b0, hold:2, reraise:1'b0};
        tbl[4] = '{raise:4'b0000, row:2'd0, col:4'd0, chr:8'h00, exp_id:1, e_row:2'd2, e_col:4'd6, e_char:8'h55, busy:3, early:1'b0, hold:0, reraise:1'b0};
        tbl[5] = '{raise:4'b0000, row:2'd0, col:4'd0, chr:8'h00, exp_id:3, e_row:2'd2, e_col:4'd6, e_char:8'h55, busy:0, early:1'b0, hold:0, reraise:1'b0};
        tbl[6] = '{raise:4'b0001, row:2'd0, col:4'd3, chr:8'h30, exp_id:0, e_row:2'd0, e_col:4'd3, e_char:8'h30, busy:2, early:1'b1, hold:0, reraise:1'b0};
        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < N; i++) begin
                if (tbl[v].raise[i]) set_data(i, tbl[v].row, tbl[v].col, tbl[v].chr);
            end
            run_txn(tbl[v].raise, tbl[v].exp_id, tbl[v].e_row, tbl[v].e_col, tbl[v].e_char,
                    tbl[v].busy, tbl[v].early, tbl[v].hold, tbl[v].reraise, 1'b0);
        end

        // Randomized traffic against the round-robin model.
        do_reset();
        m_last = N - 1;
        for (int t = 0; t < 100; t++) begin
            raise = N'($urandom) & ~req_req;
            if ((req_req | raise) == '0) raise = N'(1) << $urandom_range(0, N - 1);
            scribble_data(raise);
            exp   = rr_pick(m_last, req_req | raise);
            busy  = $urandom_range(0, 3);
            early = (busy > 0) && ($urandom_range(0, 3) == 0);
            hold  = early ? 0 : $urandom_range(0, 2);
            run_txn(raise, exp, req_row[2*exp +: 2], req_col[4*exp +: 4], req_char[8*exp +: 8],
                    busy, early, hold, 1'b0, 1'b1);
            m_last = exp;
        end

`ifdef LCD_ARB_TIMEOUT_EN
        // Driver never answers: watchdog must end the transaction after 20 cycles.
        do_reset();
        set_data(0, 2'd1, 4'd2, 8'h5A);
        req_req = 4'b0001;
        step();
        chk("wd grant", 32'(drv_req), 32'd1);
        drv_busy = 1'b1;
        for (int k = 1; k < 20; k++) begin
            step();
            chk("wd drv_req held", 32'(drv_req), 32'd1);
            chk("wd no err yet", 32'(err_timeout), 32'd0);
        end
        step();
        chk("wd drv_req drop", 32'(drv_req), 32'd0);
        chk("wd done pulse", 32'(req_done), 32'(4'b0001));
        chk("wd err set", 32'(err_timeout), 32'd1);
        drv_busy = 1'b0;
        req_req = '0;
        step();
        chk("wd single pulse", 32'(req_done), 32'd0);
        chk("wd idle", 32'(grant_valid), 32'd0);
        repeat (3) step();
        chk("wd err sticky", 32'(err_timeout), 32'd1);
        $display("txn watchdog checks=%0d fails=%0d", n_checks, n_fail);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
